// File: rtl/uart_link_pkg.sv
// Shared definitions for the UART ALU link framers (receive parser and result transmitter).
// Holds framer state encodings, frame byte positions and the default frame header.
package uart_link_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } link_state_t;

    // Byte positions inside a 3-byte frame: header, payload, checksum.
    localparam logic [1:0] IDX_HDR = 2'd0;
    localparam logic [1:0] IDX_RES = 2'd1;
    localparam logic [1:0] IDX_CHK = 2'd2;

    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

endpackage

// File: rtl/uart_tx_watchdog.sv
// Cycle watchdog for one transmitted byte; counts while enabled, expires on its last cycle.
// Latency: o_expire is combinational in the cycle the count reaches TIMEOUT_CYCLES-1; no backpressure.
module uart_tx_watchdog #(
    parameter int NB_TIMEOUT     = 16,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam logic [NB_TIMEOUT-1:0] LAST_CNT = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

    logic [NB_TIMEOUT-1:0] r_count;

    // Saturates at the last count so a stalled owner can never see the counter wrap.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LAST_CNT)) begin
            r_count <= r_count + NB_TIMEOUT'(1);
        end
    end

    assign o_expire = i_enable && (r_count == LAST_CNT);

endmodule

// File: rtl/alu_result_tx.sv
// Frames each ALU result as {HEADER, result, HEADER^result} and feeds uart_tx byte by byte.
// Latency i_valid -> first o_tx_start is 2 cycles; one pending slot, further results drop with o_overrun.
module alu_result_tx
    import uart_link_pkg::*;
#(
    parameter int                 NB_DATA        = 8,
    parameter logic [NB_DATA-1:0] HEADER         = NB_DATA'(DEFAULT_HEADER),
    parameter int                 NB_TIMEOUT     = 16,
    parameter int                 TIMEOUT_CYCLES = 20000
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    input  logic [NB_DATA-1:0] i_result,
    input  logic               i_tx_done,
    output logic               o_tx_start,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_busy,
    output logic               o_overrun,
    output logic               o_timeout
);

    link_state_t               r_state;
    logic                      r_pend_vld;
    logic [NB_DATA-1:0]        r_pend_data;
    logic [2:0][NB_DATA-1:0]   r_frame;
    logic [1:0]                r_idx;
    logic                      r_tx_start;
    logic [NB_DATA-1:0]        r_tx_data;
    logic                      r_overrun;
    logic                      r_timeout;

    logic                      w_consume;
    logic                      w_accept;
    logic                      w_expire;
    logic                      w_wd_clear;
    logic                      w_wd_enable;
    logic [1:0]                w_next_idx;

    // The slot frees up in the same cycle IDLE copies it into the frame register.
    assign w_consume   = (r_state == ST_IDLE) && r_pend_vld;
    assign w_accept    = i_valid && (!r_pend_vld || w_consume);
    assign w_next_idx  = r_idx + 2'd1;
    assign w_wd_clear  = (r_state == ST_START);
    assign w_wd_enable = (r_state == ST_WAIT);

    uart_tx_watchdog #(
        .NB_TIMEOUT     (NB_TIMEOUT),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .i_rst_n  (i_rst_n),
        .i_clear  (w_wd_clear),
        .i_enable (w_wd_enable),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pend_vld  <= 1'b0;
            r_pend_data <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_overrun <= i_valid && !w_accept;
            if (w_accept) begin
                r_pend_vld  <= 1'b1;
                r_pend_data <= i_result;
            end else if (w_consume) begin
                r_pend_vld  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_frame    <= '0;
            r_idx      <= IDX_HDR;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            r_timeout  <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (r_pend_vld) begin
                        r_frame[IDX_HDR] <= HEADER;
                        r_frame[IDX_RES] <= r_pend_data;
                        r_frame[IDX_CHK] <= HEADER ^ r_pend_data;
                        r_idx            <= IDX_HDR;
                        r_tx_data        <= HEADER;
                        r_tx_start       <= 1'b1;
                        r_state          <= ST_START;
                    end
                end
                ST_START: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A done arriving on the expiry cycle still completes the byte.
                    if (i_tx_done) begin
                        if (r_idx == IDX_CHK) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_idx      <= w_next_idx;
                            r_tx_data  <= r_frame[w_next_idx];
                            r_tx_start <= 1'b1;
                            r_state    <= ST_START;
                        end
                    end else if (w_expire) begin
                        r_state   <= ST_IDLE;
                        r_timeout <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_tx_start = r_tx_start;
    assign o_tx_data  = r_tx_data;
    assign o_busy     = (r_state != ST_IDLE) || r_pend_vld;
    assign o_overrun  = r_overrun;
    assign o_timeout  = r_timeout;

endmodule

// File: tb/tb_alu_result_tx.sv
// Bench for alu_result_tx: table of single frames, then back-to-back, overrun, reset, spurious-done and timeout sequences.
module tb_alu_result_tx;

    localparam int RESP_DLY = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_valid, a_done, resp_done, man_done;
    logic [7:0] a_result, a_data;
    logic       a_start, a_busy, a_ov, a_to;
    logic       b_valid, b_done;
    logic [7:0] b_result, b_data;
    logic       b_start, b_busy, b_ov, b_to;

    always #5 clk = ~clk;
    assign a_done = resp_done | man_done;

    alu_result_tx #(.NB_DATA(8), .HEADER(8'hA5), .NB_TIMEOUT(16), .TIMEOUT_CYCLES(20000)) dut_a (
        .clk(clk), .i_rst_n(rst_n), .i_valid(a_valid), .i_result(a_result), .i_tx_done(a_done),
        .o_tx_start(a_start), .o_tx_data(a_data), .o_busy(a_busy), .o_overrun(a_ov), .o_timeout(a_to));

    alu_result_tx #(.NB_DATA(8), .HEADER(8'hA5), .NB_TIMEOUT(16), .TIMEOUT_CYCLES(8)) dut_b (
        .clk(clk), .i_rst_n(rst_n), .i_valid(b_valid), .i_result(b_result), .i_tx_done(b_done),
        .o_tx_start(b_start), .o_tx_data(b_data), .o_busy(b_busy), .o_overrun(b_ov), .o_timeout(b_to));

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    logic [7:0] exp_q[$];
    int         a_start_cycs[$];
    int         a_done_cycs[$];
    int         a_ov_cnt = 0;
    int         a_to_cnt = 0;
    int         b_to_cnt = 0;
    bit         resp_en = 1'b1;
    int         countdown = 0;
    logic [7:0] held_byte = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every byte uart_tx is told to load must match the next queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (a_start) begin
                a_start_cycs.push_back(cyc);
                held_byte = a_data;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_start: got byte %02h, required no start (cycle %0d)", a_data, cyc);
                end else begin
                    check("tx_data", 32'(a_data), 32'(exp_q.pop_front()));
                end
            end
            if (a_ov) a_ov_cnt++;
            if (a_to) a_to_cnt++;
            if (b_to) b_to_cnt++;
        end
    end

    // uart_tx model for dut_a: done RESP_DLY cycles after each start.
    initial begin
        resp_done = 1'b0;
        forever begin
            @(negedge clk);
            resp_done = 1'b0;
            if (!rst_n) begin
                countdown = 0;
            end else if (a_start) begin
                countdown = RESP_DLY;
            end else if (countdown > 0) begin
                countdown--;
                if (countdown == 0 && resp_en) begin
                    resp_done = 1'b1;
                    a_done_cycs.push_back(cyc);
                    check("tx_data_held", 32'(a_data), 32'(held_byte));
                end
            end
        end
    end

    task automatic send_a(input logic [7:0] v, output int t);
        @(negedge clk);
        a_valid  = 1'b1;
        a_result = v;
        t = cyc;
        @(negedge clk);
        a_valid = 1'b0;
    endtask

    task automatic push_frame(input logic [7:0] h, input logic [7:0] r, input logic [7:0] c);
        exp_q.push_back(h);
        exp_q.push_back(r);
        exp_q.push_back(c);
    endtask

    task automatic wait_a_idle(input int budget, output int fall_cyc);
        fall_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!a_busy && exp_q.size() == 0) begin
                fall_cyc = cyc;
                break;
            end
        end
        if (fall_cyc < 0) begin
            checks++;
            failures++;
            $display("FAIL idle_wait: got busy=%0b pending_bytes=%0d, required idle within %0d cycles", a_busy, exp_q.size(), budget);
        end
    endtask

    task automatic wait_a_starts(input int n, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (a_start_cycs.size() >= n) break;
        end
        if (i == budget) begin
            checks++;
            failures++;
            $display("FAIL start_wait: got %0d starts, required %0d", a_start_cycs.size(), n);
        end
    endtask

    typedef struct {
        logic [7:0] res;
        logic [7:0] hdr;
        logic [7:0] mid;
        logic [7:0] chk;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int t, t2, fall, n0, cnt, to_cyc, ov0;
        logic [7:0] b_exp[3];

        vecs[0] = '{8'h3C, 8'hA5, 8'h3C, 8'h99};
        vecs[1] = '{8'h01, 8'hA5, 8'h01, 8'hA4};
        vecs[2] = '{8'hFF, 8'hA5, 8'hFF, 8'h5A};
        vecs[3] = '{8'h00, 8'hA5, 8'h00, 8'hA5};
        vecs[4] = '{8'hA5, 8'hA5, 8'hA5, 8'h00};
        vecs[5] = '{8'h5A, 8'hA5, 8'h5A, 8'hFF};
        vecs[6] = '{8'h80, 8'hA5, 8'h80, 8'h25};
        vecs[7] = '{8'h7E, 8'hA5, 8'h7E, 8'hDB};

        rst_n = 1'b0; man_done = 1'b0;
        a_valid = 1'b0; a_result = 8'h00;
        b_valid = 1'b0; b_result = 8'h00; b_done = 1'b0;
        #12;
        check("rst_start", 32'(a_start), 0);
        check("rst_data", 32'(a_data), 0);
        check("rst_busy", 32'(a_busy), 0);
        check("rst_ovr_to", 32'({a_ov, a_to, b_ov, b_to, b_start, b_busy}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven single frames: bytes, N+2 latency, done->start 1 cycle, busy fall.
        for (int i = 0; i < 8; i++) begin
            a_start_cycs.delete();
            a_done_cycs.delete();
            push_frame(vecs[i].hdr, vecs[i].mid, vecs[i].chk);
            send_a(vecs[i].res, t);
            wait_a_idle(200, fall);
            check("frame_starts", 32'(a_start_cycs.size()), 3);
            check("frame_dones", 32'(a_done_cycs.size()), 3);
            if (a_start_cycs.size() == 3 && a_done_cycs.size() == 3) begin
                check("first_start_latency", 32'(a_start_cycs[0] - t), 2);
                check("done_to_start_1", 32'(a_start_cycs[1] - a_done_cycs[0]), 1);
                check("done_to_start_2", 32'(a_start_cycs[2] - a_done_cycs[1]), 1);
                check("busy_fall", 32'(fall - a_done_cycs[2]), 1);
            end
            repeat (2) @(negedge clk);
        end

        // Back-to-back: second result arrives during the first frame's result byte.
        a_start_cycs.delete(); a_done_cycs.delete(); ov0 = a_ov_cnt;
        push_frame(8'hA5, 8'h3C, 8'h99);
        send_a(8'h3C, t);
        wait_a_starts(2, 100);
        push_frame(8'hA5, 8'h01, 8'hA4);
        send_a(8'h01, t2);
        wait_a_idle(400, fall);
        check("b2b_starts", 32'(a_start_cycs.size()), 6);
        if (a_start_cycs.size() == 6 && a_done_cycs.size() >= 3)
            check("b2b_gap", 32'(a_start_cycs[3] - a_done_cycs[2]), 2);
        check("b2b_no_overrun", 32'(a_ov_cnt - ov0), 0);
        repeat (2) @(negedge clk);

        // Overrun: third result with slot full is dropped.
        a_start_cycs.delete(); a_done_cycs.delete(); ov0 = a_ov_cnt;
        push_frame(8'hA5, 8'h3C, 8'h99);
        send_a(8'h3C, t);
        wait_a_starts(1, 100);
        push_frame(8'hA5, 8'h01, 8'hA4);
        send_a(8'h01, t);
        send_a(8'h02, t2);
        check("overrun_pulse", 32'(a_ov), 1);
        @(negedge clk);
        check("overrun_one_cycle", 32'(a_ov), 0);
        wait_a_idle(400, fall);
        check("overrun_count", 32'(a_ov_cnt - ov0), 1);
        check("overrun_starts", 32'(a_start_cycs.size()), 6);
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of the result byte.
        a_start_cycs.delete(); a_done_cycs.delete();
        push_frame(8'hA5, 8'h77, 8'hD2);
        send_a(8'h77, t);
        wait_a_starts(2, 100);
        repeat (3) @(negedge clk);
        check("pre_rst_busy", 32'(a_busy), 1);
        check("pre_rst_data", 32'(a_data), 32'h77);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_outputs", 32'({a_start, a_data, a_busy, a_ov, a_to}), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n0 = a_start_cycs.size();
        repeat (100) @(negedge clk);
        check("post_rst_no_start", 32'(a_start_cycs.size() - n0), 0);
        check("post_rst_busy", 32'(a_busy), 0);

        // Spurious done in IDLE and START; bytes advance only on done in WAIT.
        resp_en = 1'b0;
        a_start_cycs.delete();
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        check("spur_idle_busy", 32'({a_busy, a_start}), 0);
        push_frame(8'hA5, 8'hFF, 8'h5A);
        send_a(8'hFF, t);
        @(negedge clk);
        check("spur_hdr_start", 32'(a_start), 1);
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        for (int b = 1; b < 3; b++) begin
            cnt = 0;
            repeat (4) begin
                @(negedge clk);
                if (a_start) cnt++;
            end
            check("spur_quiet", 32'(cnt), 0);
            man_done = 1'b1;
            @(negedge clk);
            man_done = 1'b0;
            check("spur_advance", 32'(a_start), 1);
        end
        repeat (3) @(negedge clk);
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        check("spur_done_busy", 32'(a_busy), 0);
        check("spur_bytes_left", 32'(exp_q.size()), 0);
        check("spur_starts", 32'(a_start_cycs.size()), 3);
        resp_en = 1'b1;

        // Watchdog (TIMEOUT_CYCLES=8) on dut_b: header never acknowledged.
        n0 = b_to_cnt;
        @(negedge clk);
        b_valid = 1'b1; b_result = 8'h55; t = cyc;
        @(negedge clk);
        b_valid = 1'b0;
        @(negedge clk);
        check("to_hdr_start", 32'({b_start, b_data}), 32'h1A5);
        cnt = 0; to_cyc = -1;
        repeat (15) begin
            @(negedge clk);
            if (b_start) cnt++;
            if (b_to && to_cyc < 0) to_cyc = cyc;
        end
        check("to_cycle", 32'(to_cyc - t), 11);
        check("to_count", 32'(b_to_cnt - n0), 1);
        check("to_no_restart", 32'(cnt), 0);
        check("to_idle", 32'(b_busy), 0);

        b_exp[0] = 8'hA5; b_exp[1] = 8'h10; b_exp[2] = 8'hB5;
        @(negedge clk);
        b_valid = 1'b1; b_result = 8'h10;
        @(negedge clk);
        b_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cnt = 0;
            while (!b_start && cnt < 20) begin
                @(negedge clk);
                cnt++;
            end
            check("to_next_start_seen", 32'(b_start), 1);
            check("to_next_byte", 32'(b_data), 32'(b_exp[k]));
            repeat (3) @(negedge clk);
            b_done = 1'b1;
            @(negedge clk);
            b_done = 1'b0;
        end
        @(negedge clk);
        check("to_next_idle", 32'(b_busy), 0);
        check("to_next_no_timeout", 32'(b_to_cnt - n0), 1);
        check("a_never_timeout", 32'(a_to_cnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
